// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith-31 permutation controller.
package monolith_pkg;

    localparam int MONOLITH_ROUNDS = 6;

    // Source selected for the datapath state register
    typedef enum logic [2:0] {
        LS_IN     = 3'd0,
        LS_BARS   = 3'd1,
        LS_BRICKS = 3'd2,
        LS_CONC   = 3'd3,
        LS_ARC    = 3'd4
    } layer_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONC_ISSUE,
        ST_CONC_WAIT,
        ST_BARS,
        ST_BRICKS,
        ST_ARC,
        ST_OUT,
        ST_ERR
    } ctrl_state_e;

endpackage

// File: rtl/monolith_conc_timer.sv
// Watchdog for the concrete multiplier: cleared when a multiply is launched,
// counts while waiting, flags expiry so that the controller enters ERR
// exactly TIMEOUT cycles after the conc_start cycle.
module monolith_conc_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Holds values up to TIMEOUT-2, the last waiting cycle before giving up
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on launch, advance while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // First wait cycle sees 0; expiry on the wait cycle TIMEOUT-1 after launch
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/monolith_perm_ctrl.sv
// Sequencer for one Monolith-31 permutation: initial concrete layer, then
// NUM_ROUNDS rounds of bars, bricks, concrete and round-constant add (no
// constant after the last concrete).
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for input, in_ready high
// CONC_ISSUE | one-cycle conc_start pulse, watchdog cleared
// CONC_WAIT  | waiting for concrete result, watchdog running
// BARS       | write bars layer
// BRICKS     | write bricks layer
// ARC        | add round constant rc_idx=rnd, advance round
// OUT        | result held, waiting for out_ready
// ERR        | concrete timeout, sticky until reset
module monolith_perm_ctrl
    import monolith_pkg::*;
#(
    parameter int NUM_ROUNDS = MONOLITH_ROUNDS,
    parameter int RC_IDX_W   = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                state_we,
    output logic [2:0]          layer_sel,
    output logic [RC_IDX_W-1:0] rc_idx,
    output logic                conc_start,
    input  logic                conc_valid,
    output logic                err
);

    ctrl_state_e         state_q, state_d;
    logic [RC_IDX_W-1:0] rnd_q, rnd_d;
    logic                pre_q, pre_d;
    logic                tmr_clr, tmr_en, tmr_expired;
    layer_sel_e          ls;

    monolith_conc_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_conc_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State, round counter and pre-round flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            pre_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            pre_q   <= pre_d;
        end
    end

    // Next-state logic; a concrete result wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        pre_d   = pre_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pre_d   = 1'b1;
                    rnd_d   = '0;
                    state_d = ST_CONC_ISSUE;
                end
            end
            ST_CONC_ISSUE: begin
                tmr_clr = 1'b1;
                state_d = ST_CONC_WAIT;
            end
            ST_CONC_WAIT: begin
                tmr_en = 1'b1;
                if (conc_valid) begin
                    if (pre_q) begin
                        pre_d   = 1'b0;
                        state_d = ST_BARS;
                    end else if (rnd_q == RC_IDX_W'(NUM_ROUNDS - 1)) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_ARC;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_BARS:   state_d = ST_BRICKS;
            ST_BRICKS: state_d = ST_CONC_ISSUE;
            ST_ARC: begin
                rnd_d   = rnd_q + RC_IDX_W'(1);
                state_d = ST_BARS;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs plus the two accept-style writes (IN on accept, CONC on result)
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        state_we   = 1'b0;
        ls         = LS_IN;
        rc_idx     = '0;
        conc_start = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_we = 1'b1;
                    ls       = LS_IN;
                end
            end
            ST_CONC_ISSUE: begin
                busy       = 1'b1;
                conc_start = 1'b1;
            end
            ST_CONC_WAIT: begin
                busy = 1'b1;
                if (conc_valid) begin
                    state_we = 1'b1;
                    ls       = LS_CONC;
                end
            end
            ST_BARS: begin
                busy     = 1'b1;
                state_we = 1'b1;
                ls       = LS_BARS;
            end
            ST_BRICKS: begin
                busy     = 1'b1;
                state_we = 1'b1;
                ls       = LS_BRICKS;
            end
            ST_ARC: begin
                busy     = 1'b1;
                state_we = 1'b1;
                ls       = LS_ARC;
                rc_idx   = rnd_q;
            end
            ST_OUT:  out_valid = 1'b1;
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    assign layer_sel = ls;

endmodule

// File: doc/monolith_perm_ctrl.md
Name: monolith_perm_ctrl

Overview:
Sequencing controller for one Monolith-31 permutation over the shared state register. It accepts a start handshake and steps the datapath through the phases in a fixed order. The order is: initial concrete layer, then NUM_ROUNDS rounds of bars, bricks, concrete and round-constant add, with no constant in the last round. It issues/awaits the multi-cycle circulant concrete multiplier, tracks round index, and returns the result through a valid/ready handshake.

Parameters:
NUM_ROUNDS, 6, permutation rounds after initial concrete (>=1)
RC_IDX_W, $clog2(NUM_ROUNDS), width of round-constant index
TIMEOUT, 64, max cycles in CONC_WAIT before error (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  new input state present on datapath
in_ready  out  1  controller idle, accepts input
out_valid  out  1  state register holds final permutation output
out_ready  in  1  consumer accepts output
busy  out  1  permutation in progress (not IDLE/OUT/ERR)
state_we  out  1  write enable for datapath state register
layer_sel  out  3  state-register source: IN=0, BARS=1, BRICKS=2, CONC=3, ARC=4
rc_idx  out  RC_IDX_W  round-constant ROM index, valid when layer_sel==ARC
conc_start  out  1  one-cycle pulse launching concrete multiply
conc_valid  in  1  concrete result valid (one-cycle pulse)
err  out  1  sticky concrete-timeout flag

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, round counter 0, pre flag 1, timer 0. Outputs in_ready=1, all others 0.
- States: IDLE, CONC_ISSUE, CONC_WAIT, BARS, BRICKS, ARC, OUT, ERR.
- IDLE: in_ready=1. On in_valid: state_we=1, layer_sel=IN, pre=1, rnd=0 -> CONC_ISSUE.
- CONC_ISSUE: conc_start=1 for exactly one cycle, timer cleared -> CONC_WAIT.
- CONC_WAIT: timer increments each cycle.
  - On conc_valid: state_we=1, layer_sel=CONC. Then: if pre, clear pre -> BARS; else if rnd==NUM_ROUNDS-1 -> OUT; else -> ARC.
  - If timer reaches TIMEOUT with no conc_valid: -> ERR.
- BARS: state_we=1, layer_sel=BARS -> BRICKS. BRICKS: state_we=1, layer_sel=BRICKS -> CONC_ISSUE.
- ARC: state_we=1, layer_sel=ARC, rc_idx=rnd; rnd+=1 -> BARS.
- OUT: out_valid=1, held with state_we=0 until out_ready. On out_ready -> IDLE; IDLE is never entered in the same cycle as a new accept.
- ERR: err=1, in_ready=0, busy=0, out_valid=0. Leaves only via reset.
- conc_valid outside CONC_WAIT is ignored.
- rc_idx drives 0 outside ARC.
- Only one of {IN, BARS, BRICKS, CONC, ARC} writes per cycle.
- Latency L: conc_valid arrives L>=1 cycles after the conc_start cycle.
- Cycle count: input accept at T0 gives first out_valid cycle at T0+1+L+NUM_ROUNDS*(4+L).
- Reset mid-operation always wins: return to IDLE, no pending conc_start, err cleared.

Decomposition:
- monolith_pkg: layer_sel_e enum (IN, BARS, BRICKS, CONC, ARC), ctrl_state_e enum, MONOLITH_ROUNDS=6 constant.
- Optional sub-module monolith_conc_timer: load/count/expire counter for the timeout.
- The FSM stays in monolith_perm_ctrl.

Test Plan:
- L=2, NUM_ROUNDS=6: in_valid at T0 -> out_valid first high at T0+39. Exactly 7 conc_start pulses, 6 BARS, 6 BRICKS, 5 ARC writes.
- rc_idx during ARC cycles -> 0,1,2,3,4 in order. No ARC after the final CONC write.
- out_ready low for 5 cycles in OUT -> out_valid held, state_we=0, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- conc_valid withheld, TIMEOUT=64 -> ERR 64 cycles after conc_start; err stays 1 despite in_valid. Reset -> err=0, in_ready=1.
- reset=0 asserted during round 3 CONC_WAIT -> next cycle IDLE, all outputs at reset values. A late conc_valid pulse is ignored.
- Spurious conc_valid in BARS, and in_valid held high during busy -> no extra writes, no restart, output timing unchanged.
